// File: rtl/snoopy_motion_pkg.sv
// Shared definitions for the sprite axis movers: FSM state encoding,
// direction constants and a constant-foldable clog2 helper for port widths.
package snoopy_motion_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_NEG  = 2'b01,
        S_POS  = 2'b10
    } state_t;

    localparam logic DIR_NEG = 1'b0;
    localparam logic DIR_POS = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/snoopy_speed_ramp.sv
// Speed ramp for one axis: owns the step size and the held-tick counter.
// restart drops to speed 1, hold ramps by one every ACCEL_DIV held ticks up
// to MAX_SPEED, clear returns to idle speed 0. speed_next is the value that
// speed takes after the current tick, so the mover can step by it directly.
module snoopy_speed_ramp
    import snoopy_motion_pkg::*;
#(
    parameter int  MAX_SPEED = 3,
    parameter int  ACCEL_DIV = 4,
    localparam int SPEED_W   = clog2(MAX_SPEED + 1),
    localparam int CNT_W     = (ACCEL_DIV > 1) ? clog2(ACCEL_DIV) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               restart,
    input  logic               hold,
    input  logic               clear,
    output logic [SPEED_W-1:0] speed,
    output logic [SPEED_W-1:0] speed_next
);

    logic [CNT_W-1:0] accel_cnt;
    logic [CNT_W-1:0] accel_cnt_next;

    // Next speed and held-tick count; everything holds outside tick cycles.
    always_comb begin
        speed_next     = speed;
        accel_cnt_next = accel_cnt;
        if (tick) begin
            if (clear) begin
                speed_next     = '0;
                accel_cnt_next = '0;
            end else if (restart) begin
                speed_next     = SPEED_W'(1);
                accel_cnt_next = '0;
            end else if (hold) begin
                if (accel_cnt == CNT_W'(ACCEL_DIV - 1)) begin
                    accel_cnt_next = '0;
                    if (speed < SPEED_W'(MAX_SPEED)) begin
                        speed_next = speed + SPEED_W'(1);
                    end
                end else begin
                    accel_cnt_next = accel_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Speed and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            speed     <= '0;
            accel_cnt <= '0;
        end else begin
            speed     <= speed_next;
            accel_cnt <= accel_cnt_next;
        end
    end

endmodule

// File: rtl/snoopy_axis_mover.sv
// Single-axis sprite motion controller with bounds, frame-tick enable,
// speed ramp while a direction is held and direction-reversal handling.
// Optional build macro SNOOPY_AXIS_WRAP_EN: bounds wrap instead of clamp.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   S_IDLE | no request; speed 0, position held
//   S_NEG  | moving toward MIN_POS
//   S_POS  | moving toward MAX_POS
//
// The step applied on a tick equals the speed shown after that tick, so a
// ramp increment takes effect on the tick that earns it.
module snoopy_axis_mover
    import snoopy_motion_pkg::*;
#(
    parameter int  POS_W     = 8,
    parameter int  MIN_POS   = 0,
    parameter int  MAX_POS   = 160,
    parameter int  START_POS = 0,
    parameter int  MAX_SPEED = 3,
    parameter int  ACCEL_DIV = 4,
    localparam int SPEED_W   = clog2(MAX_SPEED + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               move_neg,
    input  logic               move_pos,
    output logic [POS_W-1:0]   pos,
    output logic [SPEED_W-1:0] speed,
    output logic               moving,
    output logic               dir,
    output logic               at_min,
    output logic               at_max
);

    localparam logic [POS_W:0] MIN_EXT = (POS_W + 1)'(MIN_POS);
    localparam logic [POS_W:0] MAX_EXT = (POS_W + 1)'(MAX_POS);

    state_t             state;
    state_t             state_next;
    logic               dir_next;
    logic               req_neg;
    logic               req_pos;
    logic               ramp_restart;
    logic               ramp_hold;
    logic               ramp_clear;
    logic               step_neg;
    logic               step_pos;
    logic [SPEED_W-1:0] speed_next;
    logic [POS_W-1:0]   pos_next;
    logic [POS_W:0]     pos_ext;
    logic [POS_W:0]     step_ext;
    logic [POS_W:0]     sum_ext;

    assign req_neg = move_neg & ~move_pos;
    assign req_pos = move_pos & ~move_neg;

    snoopy_speed_ramp #(
        .MAX_SPEED (MAX_SPEED),
        .ACCEL_DIV (ACCEL_DIV)
    ) u_ramp (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .restart    (ramp_restart),
        .hold       (ramp_hold),
        .clear      (ramp_clear),
        .speed      (speed),
        .speed_next (speed_next)
    );

    // Next state, direction and ramp control from the decoded request.
    always_comb begin
        state_next   = state;
        dir_next     = dir;
        ramp_restart = 1'b0;
        ramp_hold    = 1'b0;
        ramp_clear   = 1'b0;
        step_neg     = 1'b0;
        step_pos     = 1'b0;
        if (tick) begin
            if (req_pos) begin
                state_next = S_POS;
                dir_next   = DIR_POS;
                step_pos   = 1'b1;
                if (state == S_POS) begin
                    ramp_hold = 1'b1;
                end else begin
                    ramp_restart = 1'b1;
                end
            end else if (req_neg) begin
                state_next = S_NEG;
                dir_next   = DIR_NEG;
                step_neg   = 1'b1;
                if (state == S_NEG) begin
                    ramp_hold = 1'b1;
                end else begin
                    ramp_restart = 1'b1;
                end
            end else begin
                state_next = S_IDLE;
                ramp_clear = 1'b1;
            end
        end
    end

    assign pos_ext  = {1'b0, pos};
    assign step_ext = (POS_W + 1)'(speed_next);
    assign sum_ext  = pos_ext + step_ext;

    // Bounded position update; arithmetic is one bit wider than pos so
    // neither direction can wrap through zero or 2**POS_W.
    always_comb begin
        pos_next = pos;
        if (step_pos) begin
            if (sum_ext > MAX_EXT) begin
`ifdef SNOOPY_AXIS_WRAP_EN
                pos_next = POS_W'(MIN_EXT + (sum_ext - MAX_EXT - (POS_W + 1)'(1)));
`else
                pos_next = POS_W'(MAX_POS);
`endif
            end else begin
                pos_next = POS_W'(sum_ext);
            end
        end else if (step_neg) begin
            if (pos_ext < MIN_EXT + step_ext) begin
`ifdef SNOOPY_AXIS_WRAP_EN
                pos_next = POS_W'(MAX_EXT - (MIN_EXT + step_ext - pos_ext - (POS_W + 1)'(1)));
`else
                pos_next = POS_W'(MIN_POS);
`endif
            end else begin
                pos_next = POS_W'(pos_ext - step_ext);
            end
        end
    end

    // State, direction and position registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            dir   <= DIR_NEG;
            pos   <= POS_W'(START_POS);
        end else begin
            state <= state_next;
            dir   <= dir_next;
            pos   <= pos_next;
        end
    end

    assign moving = (state != S_IDLE);
    assign at_min = (pos == POS_W'(MIN_POS));
    assign at_max = (pos == POS_W'(MAX_POS));

endmodule

// File: tb/tb_snoopy_axis_mover.sv
// Five movers with different start positions run a shared 16-tick directed
// schedule; expected outputs after each tick are queued and a negedge monitor
// compares them, holding the last expectation between ticks.
module tb_snoopy_axis_mover;

    localparam int N  = 5;
    localparam int NT = 16;

    typedef struct packed {
        logic [7:0] pos;
        logic [1:0] spd;
        logic       mv;
        logic       dir;
    } exp_t;

    logic       clock;
    logic       tick;
    logic       tick_q;
    logic       rst_v  [N];
    logic       mn     [N];
    logic       mp     [N];
    logic [7:0] pos_o  [N];
    logic [1:0] spd_o  [N];
    logic       mv_o   [N];
    logic       dir_o  [N];
    logic       amin_o [N];
    logic       amax_o [N];

    exp_t exp_q [N][$];
    exp_t cur   [N];
    bit   have  [N];
    bit   in_rst[N];

    int n_checks = 0;
    int n_fail   = 0;

    string names [N] = '{"a_s80", "b_s10", "c_s140", "d_s10neg", "e_s35rev"};
    int    start [N] = '{80, 10, 140, 10, 35};

    // Command per tick: 0 none, 1 neg, 2 pos, 3 both.
    int cmd_t [N][NT] = '{
        '{2,2,2,2,2,2,2,2,2,0,0,0,0,0,0,0},
        '{2,2,2,2,2,2,2,2,2,2,2,2,2,2,3,0},
        '{2,2,2,2,2,2,2,2,2,2,2,2,0,0,0,0},
        '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0},
        '{2,2,2,2,2,2,2,2,2,1,1,1,1,1,0,0}
    };
    int pos_t [N][NT] = '{
        '{81,82,83,84,86,88,90,92,95,80,80,80,80,80,80,80},
        '{11,12,13,14,16,18,20,22,25,28,31,34,37,40,40,40},
        '{141,142,143,144,146,148,150,152,155,158,160,160,160,160,160,160},
        '{9,8,7,6,4,2,0,0,0,0,0,0,0,0,0,0},
        '{36,37,38,39,41,43,45,47,50,49,48,47,46,44,44,44}
    };
    int spd_t [N][NT] = '{
        '{1,1,1,1,2,2,2,2,3,0,0,0,0,0,0,0},
        '{1,1,1,1,2,2,2,2,3,3,3,3,3,3,0,0},
        '{1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0},
        '{1,1,1,1,2,2,2,2,0,0,0,0,0,0,0,0},
        '{1,1,1,1,2,2,2,2,3,1,1,1,1,2,0,0}
    };
    int dir_t [N][NT] = '{
        '{1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0},
        '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1},
        '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1},
        '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0},
        '{1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0}
    };

    snoopy_axis_mover #(.START_POS(80)) u_a (
        .clock(clock), .reset(rst_v[0]), .tick(tick), .move_neg(mn[0]), .move_pos(mp[0]),
        .pos(pos_o[0]), .speed(spd_o[0]), .moving(mv_o[0]), .dir(dir_o[0]),
        .at_min(amin_o[0]), .at_max(amax_o[0]));
    snoopy_axis_mover #(.START_POS(10)) u_b (
        .clock(clock), .reset(rst_v[1]), .tick(tick), .move_neg(mn[1]), .move_pos(mp[1]),
        .pos(pos_o[1]), .speed(spd_o[1]), .moving(mv_o[1]), .dir(dir_o[1]),
        .at_min(amin_o[1]), .at_max(amax_o[1]));
    snoopy_axis_mover #(.START_POS(140)) u_c (
        .clock(clock), .reset(rst_v[2]), .tick(tick), .move_neg(mn[2]), .move_pos(mp[2]),
        .pos(pos_o[2]), .speed(spd_o[2]), .moving(mv_o[2]), .dir(dir_o[2]),
        .at_min(amin_o[2]), .at_max(amax_o[2]));
    snoopy_axis_mover #(.START_POS(10)) u_d (
        .clock(clock), .reset(rst_v[3]), .tick(tick), .move_neg(mn[3]), .move_pos(mp[3]),
        .pos(pos_o[3]), .speed(spd_o[3]), .moving(mv_o[3]), .dir(dir_o[3]),
        .at_min(amin_o[3]), .at_max(amax_o[3]));
    snoopy_axis_mover #(.START_POS(35)) u_e (
        .clock(clock), .reset(rst_v[4]), .tick(tick), .move_neg(mn[4]), .move_pos(mp[4]),
        .pos(pos_o[4]), .speed(spd_o[4]), .moving(mv_o[4]), .dir(dir_o[4]),
        .at_min(amin_o[4]), .at_max(amax_o[4]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) tick_q <= tick;

    // Monitor: take a new expectation on reset entry or after a tick edge,
    // compare every instance on every negedge.
    always @(negedge clock) begin
        bit   pop_now;
        logic e_amin;
        logic e_amax;
        for (int i = 0; i < N; i++) begin
            pop_now = 1'b0;
            if (rst_v[i] && !in_rst[i]) pop_now = 1'b1;
            else if (!rst_v[i] && tick_q === 1'b1) pop_now = 1'b1;
            in_rst[i] = rst_v[i];
            if (pop_now) begin
                if (exp_q[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s queue_empty: output update with no expectation at %0t", names[i], $time);
                end else begin
                    cur[i]  = exp_q[i].pop_front();
                    have[i] = 1'b1;
                end
            end
            if (have[i]) begin
                e_amin = (cur[i].pos == 8'd0);
                e_amax = (cur[i].pos == 8'd160);
                n_checks++;
                if (pos_o[i] !== cur[i].pos || spd_o[i] !== cur[i].spd || mv_o[i] !== cur[i].mv ||
                    dir_o[i] !== cur[i].dir || amin_o[i] !== e_amin || amax_o[i] !== e_amax) begin
                    n_fail++;
                    $display("FAIL %s outputs at %0t: got pos=%0d spd=%0d mv=%0b dir=%0b amin=%0b amax=%0b, want pos=%0d spd=%0d mv=%0b dir=%0b amin=%0b amax=%0b",
                             names[i], $time, pos_o[i], spd_o[i], mv_o[i], dir_o[i], amin_o[i], amax_o[i],
                             cur[i].pos, cur[i].spd, cur[i].mv, cur[i].dir, e_amin, e_amax);
                end
            end
        end
    end

    function automatic exp_t reset_exp(input int i);
        exp_t e;
        e.pos = 8'(start[i]);
        e.spd = 2'd0;
        e.mv  = 1'b0;
        e.dir = 1'b0;
        return e;
    endfunction

    initial begin
        exp_t e;
`ifdef SNOOPY_AXIS_WRAP_EN
        pos_t[2][10] = 0;
        for (int t = 11; t < NT; t++) pos_t[2][t] = 3;
        for (int t = 7; t < NT; t++) pos_t[3][t] = 159;
`endif
        tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            rst_v[i]  = 1'b1;
            mn[i]     = 1'b0;
            mp[i]     = 1'b0;
            have[i]   = 1'b0;
            in_rst[i] = 1'b0;
            exp_q[i].push_back(reset_exp(i));
        end
        repeat (3) @(posedge clock);
        #2;
        for (int i = 0; i < N; i++) rst_v[i] = 1'b0;

        for (int t = 0; t < NT; t++) begin
            if (t == 9) begin
                // Async reset of the 80-start mover mid-motion at pos 95.
                @(posedge clock);
                #1 tick = 1'b0;
                @(posedge clock);
                #2;
                exp_q[0].push_back(reset_exp(0));
                rst_v[0] = 1'b1;
                #1;
                n_checks++;
                if (pos_o[0] !== 8'd80 || spd_o[0] !== 2'd0 || mv_o[0] !== 1'b0 || dir_o[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_reset: got pos=%0d spd=%0d mv=%0b dir=%0b, want pos=80 spd=0 mv=0 dir=0",
                             pos_o[0], spd_o[0], mv_o[0], dir_o[0]);
                end
                @(posedge clock);
                #2 rst_v[0] = 1'b0;
            end
            // Non-tick cycle with random inputs that must be ignored.
            @(posedge clock);
            #1;
            tick = 1'b0;
            for (int i = 0; i < N; i++) begin
                mn[i] = 1'($urandom_range(0, 1));
                mp[i] = 1'($urandom_range(0, 1));
            end
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                mn[i] = (cmd_t[i][t] == 1 || cmd_t[i][t] == 3);
                mp[i] = (cmd_t[i][t] == 2 || cmd_t[i][t] == 3);
                e.pos = 8'(pos_t[i][t]);
                e.spd = 2'(spd_t[i][t]);
                e.mv  = (cmd_t[i][t] == 1 || cmd_t[i][t] == 2);
                e.dir = 1'(dir_t[i][t]);
                exp_q[i].push_back(e);
            end
            @(posedge clock);
            #1 tick = 1'b1;
        end
        @(posedge clock);
        #1 tick = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (exp_q[i].size() != 0) begin
                n_fail++;
                $display("FAIL %s drain: %0d expectations left, want 0", names[i], exp_q[i].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
